// File: rtl/pacman_pkg.sv
// Shared maze definitions: tile codes, board constants, writer FSM states.
package pacman_pkg;

  localparam int BOARD_TILES  = 868;
  localparam int PELLET_INIT  = 244;
  localparam int PACMAN_START = 495;
  localparam int BLINKY_START = 366;

  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    WALL   = 3'd1,
    PELLET = 3'd2,
    POWER  = 3'd3,
    PACMAN = 3'd4,
    BLINKY = 3'd5
  } tile_t;

  typedef enum logic [3:0] {
    IDLE, P_RD, P_WAIT, P_CLR, P_WR, B_RST, B_RD, B_WAIT, B_WR, DONE
  } state_t;

  // A move is taken only onto an on-board tile that is not a wall.
  function automatic logic move_legal(input logic [9:0] nxt, input tile_t t, input int tiles);
    return (int'(nxt) < tiles) && (t != WALL);
  endfunction

  // Tiles that count towards the pellet total when eaten.
  function automatic logic is_pellet(input tile_t t);
    return (t == PELLET) || (t == POWER);
  endfunction

  // Blinky remembers what lies beneath it; actor codes are never restored.
  function automatic tile_t under_code(input tile_t t);
    return ((t == PACMAN) || (t == BLINKY)) ? EMPTY : t;
  endfunction

endpackage

// File: rtl/board_writer.sv
// Per-frame board writer: moves Pacman then Blinky in the external board RAM,
// tracks the pellet count and reports win / collision for the pass.
module board_writer
  import pacman_pkg::*;
#(
  parameter int BOARD_TILES = pacman_pkg::BOARD_TILES,
  parameter int PELLET_INIT = pacman_pkg::PELLET_INIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       start,
  input  logic [9:0] pac_pos,
  input  logic [9:0] pac_next,
  input  logic [9:0] blinky_pos,
  input  logic [9:0] blinky_next,
  output logic [9:0] rd_addr,
  input  logic [2:0] rd_data,
  output logic       wr_en,
  output logic [9:0] wr_addr,
  output logic [2:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic [9:0] pac_final,
  output logic [9:0] blinky_final,
  output logic [7:0] pellets_left,
  output logic       win,
  output logic       collision
);

  state_t     r_state;
  state_t     w_state_next;
  logic [9:0] r_pac_pos;
  logic [9:0] r_pac_next;
  logic [9:0] r_blinky_pos;
  logic [9:0] r_blinky_next;
  logic [9:0] r_pac_final;
  logic [9:0] r_blinky_final;
  logic [7:0] r_pellets;
  tile_t      r_under;
  logic       r_pac_legal;
  logic       r_win;
  logic       r_collision;
  logic       r_load_pending;

  tile_t      w_rd_tile;
  logic [9:0] w_req_addr;
  logic       w_req_legal;
  logic       w_apply_load;

  // The tile being judged is Pacman's target in P_WAIT and Blinky's in B_WAIT.
  assign w_rd_tile    = tile_t'(rd_data);
  assign w_req_addr   = (r_state == B_WAIT) ? r_blinky_next : r_pac_next;
  assign w_req_legal  = move_legal(w_req_addr, w_rd_tile, BOARD_TILES);
  // A load seen mid-pass is held back so the pass finishes on consistent state.
  assign w_apply_load = ((r_state == IDLE) && load) ||
                        ((r_state == DONE) && (load || r_load_pending));

  assign busy         = (r_state != IDLE);
  assign pac_final    = r_pac_final;
  assign blinky_final = r_blinky_final;
  assign pellets_left = r_pellets;
  assign win          = r_win;
  assign collision    = r_collision;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state sequencing and RAM port drive; one RAM access per state.
  always_comb begin
    w_state_next = r_state;
    rd_addr      = '0;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = EMPTY;
    done         = 1'b0;
    case (r_state)
      IDLE:   if (start) w_state_next = P_RD;
      P_RD: begin
        rd_addr      = r_pac_next;
        w_state_next = P_WAIT;
      end
      P_WAIT: w_state_next = P_CLR;
      P_CLR: begin
        wr_en        = r_pac_legal;
        wr_addr      = r_pac_legal ? r_pac_pos : 10'd0;
        w_state_next = P_WR;
      end
      P_WR: begin
        wr_en        = 1'b1;
        wr_addr      = r_pac_final;
        wr_data      = PACMAN;
        w_state_next = B_RST;
      end
      B_RST: begin
        wr_en        = 1'b1;
        wr_addr      = r_blinky_pos;
        wr_data      = r_under;
        w_state_next = B_RD;
      end
      B_RD: begin
        rd_addr      = r_blinky_next;
        w_state_next = B_WAIT;
      end
      B_WAIT: w_state_next = B_WR;
      B_WR: begin
        wr_en        = 1'b1;
        wr_addr      = r_blinky_final;
        wr_data      = BLINKY;
        w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Pass datapath: latch requests, judge moves, keep pellet and status state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pac_pos      <= '0;
      r_pac_next     <= '0;
      r_blinky_pos   <= '0;
      r_blinky_next  <= '0;
      r_pac_final    <= 10'(PACMAN_START);
      r_blinky_final <= 10'(BLINKY_START);
      r_pellets      <= 8'(PELLET_INIT);
      r_under        <= EMPTY;
      r_pac_legal    <= 1'b0;
      r_win          <= 1'b0;
      r_collision    <= 1'b0;
      r_load_pending <= 1'b0;
    end else begin
      if ((r_state == IDLE) && start) begin
        r_pac_pos     <= pac_pos;
        r_pac_next    <= pac_next;
        r_blinky_pos  <= blinky_pos;
        r_blinky_next <= blinky_next;
      end
      if (r_state == P_WAIT) begin
        r_pac_legal <= w_req_legal;
        r_pac_final <= w_req_legal ? r_pac_next : r_pac_pos;
        if (w_req_legal && is_pellet(w_rd_tile) && (r_pellets != 8'd0))
          r_pellets <= r_pellets - 8'd1;
      end
      if (r_state == B_WAIT) begin
        r_blinky_final <= w_req_legal ? r_blinky_next : r_blinky_pos;
        // A blocked Blinky stays on the tile it already remembers.
        if (w_req_legal) r_under <= under_code(w_rd_tile);
      end
      if (r_state == B_WR) begin
        r_win       <= (r_pellets == 8'd0);
        r_collision <= (r_blinky_final == r_pac_final) ||
                       ((r_pac_final == r_blinky_pos) && (r_blinky_final == r_pac_pos));
      end
      if (load && (r_state != IDLE) && (r_state != DONE)) r_load_pending <= 1'b1;
      else if (r_state == DONE)                           r_load_pending <= 1'b0;
      if (w_apply_load) begin
        r_pellets   <= 8'(PELLET_INIT);
        r_under     <= EMPTY;
        r_win       <= 1'b0;
        r_collision <= 1'b0;
      end
    end
  end

endmodule
